// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder
// Description : Word RAM serving the CPU memory port with a 1-cycle registered
//               read. A handshaked host port loads and reads the RAM and
//               freezes the CPU through o_cpu_enable while it is being served.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_write_en,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [31:0]           i_cpu_data,
  output logic [31:0]           o_cpu_data,
  output logic                  o_cpu_enable,
  input  logic                  i_host_req,
  input  logic                  i_host_write_en,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [31:0]           i_host_data,
  output logic                  o_host_ack,
  output logic [31:0]           o_host_data
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOST_ACCESS = 2'd1,
    HOST_ACK    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]      r_mem [0:DEPTH-1];
  logic [31:0]      r_cpu_data;
  logic [31:0]      r_host_data;

  logic [IDX_W-1:0] w_cpu_idx;
  logic [IDX_W-1:0] w_host_idx;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_mem_idx;
  logic [31:0]      w_mem_wdata;

  // Low two address bits select a byte within the word and are dropped.
  assign w_cpu_idx  = i_cpu_addr[ADDR_WIDTH-1:2];
  assign w_host_idx = i_host_addr[ADDR_WIDTH-1:2];

  // State register; reset abandons any host access in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs; the CPU owns the RAM only in IDLE.
  always_comb begin
    w_next_state = r_state;
    o_cpu_enable = 1'b0;
    o_host_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        o_cpu_enable = 1'b1;
        if (i_host_req) begin
          w_next_state = HOST_ACCESS;
        end
      end
      HOST_ACCESS: begin
        w_next_state = HOST_ACK;
      end
      HOST_ACK: begin
        o_host_ack   = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Single write port shared by both sides; ownership follows the state, and
  // a write coinciding with reset is dropped.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_cpu_idx;
    w_mem_wdata = i_cpu_data;
    if (!i_rst) begin
      case (r_state)
        IDLE: begin
          w_mem_we = i_cpu_write_en;
        end
        HOST_ACCESS: begin
          w_mem_we    = i_host_write_en;
          w_mem_idx   = w_host_idx;
          w_mem_wdata = i_host_data;
        end
        default: begin
          w_mem_we = 1'b0;
        end
      endcase
    end
  end

  // RAM array write; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  // CPU read data, read-first, updated only on CPU-owned edges so it holds
  // through a host freeze.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpu_data <= '0;
    end else if (r_state == IDLE) begin
      r_cpu_data <= r_mem[w_cpu_idx];
    end
  end

  // Host read data, captured during a host read access and held afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_host_data <= '0;
    end else if (r_state == HOST_ACCESS && !i_host_write_en) begin
      r_host_data <= r_mem[w_host_idx];
    end
  end

  assign o_cpu_data  = r_cpu_data;
  assign o_host_data = r_host_data;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_responder
// Description : Directed self-checking bench for cpu_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

  localparam int AW = 14;

  logic          i_clk;
  logic          i_rst;
  logic          i_cpu_write_en;
  logic [AW-1:0] i_cpu_addr;
  logic [31:0]   i_cpu_data;
  logic [31:0]   o_cpu_data;
  logic          o_cpu_enable;
  logic          i_host_req;
  logic          i_host_write_en;
  logic [AW-1:0] i_host_addr;
  logic [31:0]   i_host_data;
  logic          o_host_ack;
  logic [31:0]   o_host_data;

  int checks;
  int errors;

  cpu_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_cpu_write_en  (i_cpu_write_en),
    .i_cpu_addr      (i_cpu_addr),
    .i_cpu_data      (i_cpu_data),
    .o_cpu_data      (o_cpu_data),
    .o_cpu_enable    (o_cpu_enable),
    .i_host_req      (i_host_req),
    .i_host_write_en (i_host_write_en),
    .i_host_addr     (i_host_addr),
    .i_host_data     (i_host_data),
    .o_host_ack      (o_host_ack),
    .o_host_data     (o_host_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full host transaction with a bounded wait for the ack.
  task automatic host_access(input string tag, input logic we, input logic [AW-1:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    i_host_req      = 1'b1;
    i_host_write_en = we;
    i_host_addr     = addr;
    i_host_data     = wdata;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_host_ack && n < 6);
    chk({tag, "_ack_latency"}, 32'(n), 32'd2);
    rdata      = o_host_data;
    i_host_req = 1'b0;
    tick();
  endtask

  logic [31:0] rd;

  initial begin
    checks          = 0;
    errors          = 0;
    i_rst           = 1'b1;
    i_cpu_write_en  = 1'b0;
    i_cpu_addr      = '0;
    i_cpu_data      = '0;
    i_host_req      = 1'b1;   // must be ignored during reset
    i_host_write_en = 1'b0;
    i_host_addr     = '0;
    i_host_data     = '0;

    // Reset state
    tick();
    tick();
    chk("rst_cpu_enable", 32'(o_cpu_enable), 32'd1);
    chk("rst_host_ack",   32'(o_host_ack),   32'd0);
    chk("rst_cpu_data",   o_cpu_data,        32'h0);
    chk("rst_host_data",  o_host_data,       32'h0);
    i_host_req = 1'b0;
    i_rst      = 1'b0;
    tick();
    chk("idle_enable", 32'(o_cpu_enable), 32'd1);

    // Host write 0xDEADBEEF to 0x0010, step by step
    i_host_req      = 1'b1;
    i_host_write_en = 1'b1;
    i_host_addr     = 14'h0010;
    i_host_data     = 32'hDEADBEEF;
    tick();
    chk("hw_access_enable", 32'(o_cpu_enable), 32'd0);
    chk("hw_access_ack",    32'(o_host_ack),   32'd0);
    tick();
    chk("hw_ack",        32'(o_host_ack),   32'd1);
    chk("hw_ack_enable", 32'(o_cpu_enable), 32'd0);
    i_host_req = 1'b0;
    tick();
    chk("hw_post_ack",    32'(o_host_ack),   32'd0);
    chk("hw_post_enable", 32'(o_cpu_enable), 32'd1);

    // CPU read with low address bits set
    i_cpu_addr = 14'h0013;
    tick();
    chk("cpu_read_0x13", o_cpu_data, 32'hDEADBEEF);

    // Known old value at 0x0100, then CPU read-first write
    host_access("preload100", 1'b1, 14'h0100, 32'hA5A5A5A5, rd);
    i_cpu_addr     = 14'h0100;
    i_cpu_write_en = 1'b1;
    i_cpu_data     = 32'h12345678;
    tick();
    chk("cpu_wr_read_first", o_cpu_data, 32'hA5A5A5A5);
    i_cpu_write_en = 1'b0;
    tick();
    chk("cpu_wr_new_value", o_cpu_data, 32'h12345678);

    // Host read of 0x0100; CPU address moves during the freeze
    i_host_req      = 1'b1;
    i_host_write_en = 1'b0;
    i_host_addr     = 14'h0100;
    tick();
    chk("hr_cpu_data_edge", o_cpu_data, 32'h12345678);
    i_cpu_addr = 14'h0010;
    tick();
    chk("hr_ack",          32'(o_host_ack), 32'd1);
    chk("hr_host_data",    o_host_data,     32'h12345678);
    chk("hr_cpu_frozen1",  o_cpu_data,      32'h12345678);
    i_host_req = 1'b0;
    tick();
    chk("hr_ack_drop",     32'(o_host_ack), 32'd0);
    chk("hr_host_held",    o_host_data,     32'h12345678);
    chk("hr_cpu_frozen2",  o_cpu_data,      32'h12345678);
    tick();
    chk("hr_cpu_resume",   o_cpu_data,      32'hDEADBEEF);

    // CPU write held across a freeze lands only on CPU-owned edges
    i_cpu_addr      = 14'h0300;
    i_cpu_write_en  = 1'b1;
    i_cpu_data      = 32'h0BADF00D;
    i_host_req      = 1'b1;
    i_host_write_en = 1'b1;
    i_host_addr     = 14'h0300;
    i_host_data     = 32'h55AA55AA;
    tick();                          // CPU writes 0BADF00D, host sampled
    tick();                          // host writes 55AA55AA (CPU frozen)
    i_host_req = 1'b0;
    tick();                          // ack cycle ends, CPU still frozen
    i_cpu_write_en = 1'b0;
    tick();                          // IDLE edge: read word 0x300
    chk("frozen_cpu_write", o_cpu_data, 32'h55AA55AA);

    // Host request held high for 9 cycles
    i_host_req      = 1'b1;
    i_host_write_en = 1'b0;
    i_host_addr     = 14'h0010;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("held_ack_%0d", i),    32'(o_host_ack),   32'((i % 3) == 1));
      chk($sformatf("held_enable_%0d", i), 32'(o_cpu_enable), 32'((i % 3) == 2));
    end
    i_host_req = 1'b0;
    chk("held_host_data", o_host_data, 32'hDEADBEEF);
    tick();

    // Reset during a host write access
    host_access("preload200", 1'b1, 14'h0200, 32'h11112222, rd);
    i_host_req      = 1'b1;
    i_host_write_en = 1'b1;
    i_host_addr     = 14'h0200;
    i_host_data     = 32'hCAFEF00D;
    tick();
    chk("abort_in_access", 32'(o_cpu_enable), 32'd0);
    i_rst = 1'b1;
    tick();
    chk("abort_no_ack",    32'(o_host_ack),   32'd0);
    chk("abort_enable",    32'(o_cpu_enable), 32'd1);
    chk("abort_host_data", o_host_data,       32'h0);
    i_rst      = 1'b0;
    i_host_req = 1'b0;
    tick();
    chk("abort_idle_ack",    32'(o_host_ack),   32'd0);
    chk("abort_idle_enable", 32'(o_cpu_enable), 32'd1);
    host_access("readback200", 1'b0, 14'h0200, 32'h0, rd);
    chk("abort_readback", rd, 32'h11112222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
